// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the console UART transmitter
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock byte FIFO with separate occupancy counter
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // Overflow and underflow requests are dropped silently.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1/8N2 UART transmitter for the console path
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    input  logic [7:0]                    i_data,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    uart_tx_state_e          state;
    uart_tx_state_e          state_next;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BAUD_W-1:0]       baud_next;
    logic [2:0]              bit_idx;
    logic [2:0]              bit_next;
    logic                    stop_idx;
    logic                    stop_next;
    logic [UART_DATA_W-1:0]  shift;
    logic [UART_DATA_W-1:0]  shift_next;
    logic                    tx_reg;
    logic                    tx_next;
    logic                    baud_last;

    logic                    fifo_pop;
    logic [UART_DATA_W-1:0]  fifo_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [LVL_W-1:0]        fifo_count;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (i_valid),
        .push_data (i_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);

    assign o_ready = !fifo_full;
    assign o_level = fifo_count;
    assign o_busy  = (state != IDLE) || !fifo_empty;
    assign o_tx    = tx_reg;

    // State, timing counters and shift register; line level lags state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            tx_reg   <= UART_IDLE_LVL;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            stop_idx <= stop_next;
            shift    <= shift_next;
            tx_reg   <= tx_next;
        end
    end

    // Next-state logic: frame sequencing, pops, and the line level for the current state.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BAUD_W'(1);
        bit_next   = bit_idx;
        stop_next  = stop_idx;
        shift_next = shift;
        fifo_pop   = 1'b0;
        tx_next    = UART_IDLE_LVL;

        case (state)
            IDLE: begin
                tx_next   = UART_IDLE_LVL;
                baud_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_data;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        stop_next  = 1'b0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_next = UART_IDLE_LVL;
                if (baud_last) begin
                    baud_next = '0;
                    if (stop_idx == STOP_LAST) begin
                        // Chaining straight into START keeps back-to-back frames gapless.
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            shift_next = fifo_data;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        stop_next = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
